// File: rtl/mips_cpu_hilo_muldiv_ctrl.sv
// HI/LO owner with an iterative radix-2 mul/div engine: WIDTH step cycles plus one fix-up cycle.
// MFHI/MFLO/MTHI/MTLO are single-cycle in IDLE; any HI/LO op stalls while the engine is busy.
`timescale 1ns/1ps
module mips_cpu_hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             kill,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [4:0] OP_MULTU = 5'b00111;
  localparam logic [4:0] OP_MULT  = 5'b01000;
  localparam logic [4:0] OP_DIV   = 5'b01111;
  localparam logic [4:0] OP_DIVU  = 5'b10000;
  localparam logic [4:0] OP_MTHI  = 5'b10001;
  localparam logic [4:0] OP_MTLO  = 5'b10010;
  localparam logic [4:0] OP_MFHI  = 5'b11010;
  localparam logic [4:0] OP_MFLO  = 5'b11011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  // acc_hi holds partial product high half / partial remainder;
  // acc_lo holds the multiplier being shifted out / the quotient being shifted in.
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic            is_div_q, is_div_d;
  logic            neg_q, neg_d;
  logic            sgn_a_q, sgn_a_d;
  logic            dz_q, dz_d;

  logic            is_muldiv, is_signed, is_div_op, is_hilo;
  logic            sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]  mul_sum;
  logic [WIDTH:0]  div_sh;
  logic [WIDTH:0]  div_diff;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    is_muldiv = (alucontrol == OP_MULTU) || (alucontrol == OP_MULT) ||
                (alucontrol == OP_DIV)   || (alucontrol == OP_DIVU);
    is_signed = (alucontrol == OP_MULT) || (alucontrol == OP_DIV);
    is_div_op = (alucontrol == OP_DIV) || (alucontrol == OP_DIVU);
    is_hilo   = is_muldiv ||
                (alucontrol == OP_MTHI) || (alucontrol == OP_MTLO) ||
                (alucontrol == OP_MFHI) || (alucontrol == OP_MFLO);
    sign_a    = is_signed & srca[WIDTH-1];
    sign_b    = is_signed & srcb[WIDTH-1];
    abs_a     = sign_a ? -srca : srca;
    abs_b     = sign_b ? -srcb : srcb;
  end

  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    prod_mag = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? -prod_mag : prod_mag;
    quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
    rem_fix  = sgn_a_q ? -acc_hi_q : acc_hi_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    dvd_d    = dvd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sgn_a_d  = sgn_a_q;
    dz_d     = dz_q;

    case (state_q)
      S_IDLE: begin
        if (op_valid && !kill) begin
          if (is_muldiv) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            acc_hi_d = '0;
            acc_lo_d = is_div_op ? abs_a : abs_b;
            opnd_d   = is_div_op ? abs_b : abs_a;
            dvd_d    = srca;
            is_div_d = is_div_op;
            neg_d    = sign_a ^ sign_b;
            sgn_a_d  = sign_a;
            dz_d     = (srcb == '0);
          end else if (alucontrol == OP_MTHI) begin
            hi_d = srca;
          end else if (alucontrol == OP_MTLO) begin
            lo_d = srca;
          end
        end
      end
      S_RUN: begin
        if (kill) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (is_div_q) begin
            // Restoring step: keep the trial difference only when it did not borrow.
            acc_hi_d = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (!kill) begin
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = dvd_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      dvd_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sgn_a_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      dvd_q    <= dvd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sgn_a_q  <= sgn_a_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    stall = op_valid & busy_q & is_hilo;
    busy  = busy_q;
    hi    = hi_q;
    lo    = lo_q;
    case (alucontrol)
      OP_MFHI: rd_data = hi_q;
      OP_MFLO: rd_data = lo_q;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_cpu_hilo_muldiv_ctrl.sv
// Directed bench for the HI/LO mul/div controller; expected HI/LO results queue up at issue time.
`timescale 1ns/1ps
module tb_mips_cpu_hilo_muldiv_ctrl;

  localparam logic [4:0] OP_MULTU = 5'b00111;
  localparam logic [4:0] OP_MULT  = 5'b01000;
  localparam logic [4:0] OP_DIV   = 5'b01111;
  localparam logic [4:0] OP_DIVU  = 5'b10000;
  localparam logic [4:0] OP_MTHI  = 5'b10001;
  localparam logic [4:0] OP_MTLO  = 5'b10010;
  localparam logic [4:0] OP_MFHI  = 5'b11010;
  localparam logic [4:0] OP_MFLO  = 5'b11011;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [4:0]  alucontrol;
  logic [31:0] srca, srcb;
  logic        kill;
  logic        stall, busy;
  logic [31:0] rd_data, hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_hi   = 32'h0;
  logic [31:0] exp_lo   = 32'h0;

  mips_cpu_hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .kill       (kill),
    .stall      (stall),
    .busy       (busy),
    .rd_data    (rd_data),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sa, sbv, r64;
    logic [63:0] u64;
    sa  = $signed({{32{a[31]}}, a});
    sbv = $signed({{32{b[31]}}, b});
    h = 32'h0;
    l = 32'h0;
    case (code)
      OP_MULTU: begin u64 = {32'h0, a} * {32'h0, b}; h = u64[63:32]; l = u64[31:0]; end
      OP_MULT:  begin r64 = sa * sbv; h = r64[63:32]; l = r64[31:0]; end
      OP_DIV: begin
        if (b == 32'h0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin r64 = sa / sbv; l = r64[31:0]; r64 = sa % sbv; h = r64[31:0]; end
      end
      OP_DIVU: begin
        if (b == 32'h0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1; alucontrol = code; srca = a; srcb = b;
    @(negedge clk);
    op_valid = 1'b0; alucontrol = 5'b00000;
  endtask

  task automatic wait_done(input string tag);
    int cnt;
    exp_t e;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 32'(cnt), 32'd33);
    check({tag, " busy_after"}, {31'h0, busy}, 32'h0);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'h1, 32'h0);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, " hi"}, hi, e.hi);
      check({e.tag, " lo"}, lo, e.lo);
      exp_hi = e.hi;
      exp_lo = e.lo;
    end
  endtask

  task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string tag);
    exp_t e;
    e.hi = eh; e.lo = el; e.tag = tag;
    sb_q.push_back(e);
    issue(code, a, b);
    wait_done(tag);
  endtask

  initial begin
    logic [31:0] mh, ml, ra, rb;
    logic [4:0]  rc;
    int          cnt;
    exp_t        e;
    logic [4:0]  codes [4];
    codes[0] = OP_MULTU; codes[1] = OP_MULT; codes[2] = OP_DIV; codes[3] = OP_DIVU;

    reset = 1'b0; op_valid = 1'b0; alucontrol = 5'b0; srca = 32'h0; srcb = 32'h0; kill = 1'b0;
    #12;
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    op_valid = 1'b1; alucontrol = OP_MFHI;
    #1;
    check("reset stall", {31'h0, stall}, 32'h0);
    check("reset rd_data", rd_data, 32'h0);
    op_valid = 1'b0; alucontrol = 5'b0;
    @(negedge clk);
    reset = 1'b1;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(OP_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, "divu_zero");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");

    for (int i = 0; i < 6; i++) begin
      rc = codes[i % 4];
      ra = $urandom;
      rb = (i == 5) ? 32'h0 : $urandom;
      if (i == 2) rb = rb >> 20;
      model(rc, ra, rb, mh, ml);
      run_op(rc, ra, rb, mh, ml, $sformatf("rand%0d", i));
    end

    // MFLO issued right behind a DIVU must stall until the quotient lands.
    e.hi = 32'd2; e.lo = 32'd14; e.tag = "divu_100_7";
    sb_q.push_back(e);
    @(negedge clk);
    op_valid = 1'b1; alucontrol = OP_DIVU; srca = 32'd100; srcb = 32'd7;
    @(negedge clk);
    alucontrol = OP_MFLO;
    #1;
    cnt = 0;
    while (stall === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check("mflo stall_cycles", 32'(cnt), 32'd33);
    check("mflo rd_data", rd_data, 32'd14);
    e = sb_q.pop_front();
    check({e.tag, " hi"}, hi, e.hi);
    check({e.tag, " lo"}, lo, e.lo);
    exp_hi = e.hi; exp_lo = e.lo;
    alucontrol = OP_MFHI;
    #1;
    check("mfhi rd_data", rd_data, 32'd2);
    check("mfhi stall", {31'h0, stall}, 32'h0);
    op_valid = 1'b0; alucontrol = 5'b0;

    @(negedge clk);
    op_valid = 1'b1; alucontrol = OP_MTLO; srca = 32'hA5A5_A5A5;
    #1;
    check("mtlo busy_same", {31'h0, busy}, 32'h0);
    @(negedge clk);
    op_valid = 1'b0; alucontrol = 5'b0;
    exp_lo = 32'hA5A5_A5A5;
    check("mtlo lo", lo, exp_lo);
    check("mtlo busy", {31'h0, busy}, 32'h0);
    check("mtlo hi", hi, exp_hi);

    @(negedge clk);
    op_valid = 1'b1; alucontrol = OP_MTHI; srca = 32'h1357_9BDF;
    @(negedge clk);
    op_valid = 1'b0; alucontrol = 5'b0;
    exp_hi = 32'h1357_9BDF;
    check("mthi hi", hi, exp_hi);

    @(negedge clk);
    op_valid = 1'b1; alucontrol = OP_MTLO; srca = 32'hDEAD_BEEF; kill = 1'b1;
    @(negedge clk);
    op_valid = 1'b1; alucontrol = OP_MULTU; srca = 32'h3; srcb = 32'h3;
    @(negedge clk);
    op_valid = 1'b0; alucontrol = 5'b0; kill = 1'b0;
    check("kill_idle lo", lo, exp_lo);
    check("kill_idle busy", {31'h0, busy}, 32'h0);

    @(negedge clk);
    op_valid = 1'b1; alucontrol = 5'b00000; srca = 32'hFFFF_0000;
    #1;
    check("unused rd_data", rd_data, 32'h0);
    check("unused stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    op_valid = 1'b0;
    check("unused busy", {31'h0, busy}, 32'h0);
    check("unused hi", hi, exp_hi);

    issue(OP_MULTU, 32'h0000_1234, 32'h0000_5678);
    repeat (5) @(negedge clk);
    op_valid = 1'b1; alucontrol = 5'b00010;
    #1;
    check("busy other_code stall", {31'h0, stall}, 32'h0);
    op_valid = 1'b0; alucontrol = 5'b0;
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_run busy", {31'h0, busy}, 32'h0);
    check("kill_run hi", hi, exp_hi);
    check("kill_run lo", lo, exp_lo);
    repeat (40) @(negedge clk);
    check("kill_run lo_later", lo, exp_lo);

    // Kill landing exactly on the fix-up cycle must still discard the result.
    issue(OP_MULTU, 32'h0000_0007, 32'h0000_0009);
    repeat (32) @(negedge clk);
    check("kill_fix busy_pre", {31'h0, busy}, 32'h1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_fix busy", {31'h0, busy}, 32'h0);
    check("kill_fix hi", hi, exp_hi);
    check("kill_fix lo", lo, exp_lo);

    issue(OP_MULTU, 32'h0000_0100, 32'h0000_0100);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset hi", hi, 32'h0);
    check("async_reset lo", lo, 32'h0);
    check("async_reset busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    exp_hi = 32'h0; exp_lo = 32'h0;
    run_op(OP_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, "multu_3x4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_hilo_muldiv_ctrl.md
Name: mips_cpu_hilo_muldiv_ctrl

Overview:
- Owns the HI/LO architectural registers and sequences an iterative radix-2 multiply/divide engine for MULT, MULTU, DIV and DIVU.
- Services MTHI, MTLO, MFHI and MFLO, and raises a pipeline stall while a long operation is in flight.
- Sits beside the main ALU in the execute stage and is driven by the same 5-bit alucontrol encoding the ALU decoder produces.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count per mul/div = WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- op_valid  input  1  execute stage presents an instruction this cycle.
- alucontrol  input  5  operation code:
  - 00111 MULTU, 01000 MULT, 01111 DIV, 10000 DIVU
  - 10001 MTHI, 10010 MTLO, 11010 MFHI, 11011 MFLO
  - all other codes: ignored.
- srca  input  WIDTH  rs operand (dividend / multiplicand / MT data).
- srcb  input  WIDTH  rt operand (divisor / multiplier).
- kill  input  1  pipeline flush; aborts any in-flight op.
- stall  output  1  hold execute stage; instruction not accepted.
- busy  output  1  engine running.
- rd_data  output  WIDTH  HI (MFHI) or LO (MFLO); 0 for other codes.
- hi  output  WIDTH  current HI.
- lo  output  WIDTH  current LO.

Behaviour:
- Reset (asynchronous, while reset=0):
  - hi=0, lo=0, state=IDLE, counter=0, busy=0.
  - stall is combinational and therefore 0.
  - Reset mid-operation discards the operation.
- States: IDLE, RUN, FIX.
  - busy = (state != IDLE).
- Accept condition: in IDLE with op_valid=1, kill=0 and a MULT/MULTU/DIV/DIVU code, the op is accepted at that edge.
  - Signed ops capture |srca| and |srcb| plus sign flags; unsigned ops capture the operands as-is.
  - Next state is RUN with counter=0.
- RUN:
  - One shift-add (multiply) or restoring-subtract (divide) step per cycle.
  - After WIDTH RUN cycles, go to FIX.
- FIX:
  - Apply sign correction and write hi/lo at the edge, then return to IDLE.
  - Multiply: {hi,lo} = 2*WIDTH-bit product, negated if the operand signs differ (signed only).
  - Divide: lo = quotient, negated if the signs differ; hi = remainder, carrying the sign of the dividend.
- Latency: op accepted at edge N.
  - busy=1 during cycles N+1 .. N+WIDTH+1.
  - New hi/lo visible, and busy=0, from cycle N+WIDTH+2 (34 cycles for WIDTH=32).
- Divide by zero (either signedness):
  - lo = all ones, hi = srca as captured (original dividend, not its magnitude).
  - Full latency still applies.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO in IDLE, kill=0: hi/lo = srca at that edge. Single cycle; busy stays 0.
- MFHI/MFLO in IDLE: rd_data = hi/lo combinationally in the same cycle; no stall.
- stall = op_valid & busy & (code is any of the 8 HI/LO codes).
  - A stalled instruction is not accepted; the pipeline re-presents it.
  - No queueing; other codes never stall.
- kill:
  - In RUN or FIX, kill forces IDLE at the next edge; hi/lo are unchanged, including a FIX that coincides with kill.
  - In IDLE, kill blocks acceptance of any op that cycle, MT* included.
- Unused alucontrol codes with op_valid=1: no state change; rd_data=0.

Test Plan:
- MULTU srca=0xFFFFFFFF srcb=0xFFFFFFFF -> busy for 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001, busy=0.
- MULT srca=0xFFFFFFFD (-3) srcb=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV srca=0xFFFFFFF9 (-7) srcb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU srca=0x12345678 srcb=0 -> after 34 cycles lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU 100/7, then present MFLO on the next cycle -> stall=1 for 33 cycles, then stall=0 and rd_data=14. MFHI then gives 2.
- MTLO srca=0xA5A5A5A5 in IDLE -> lo=0xA5A5A5A5 next cycle, busy never set. MULTU mid-RUN + kill=1 -> busy=0 next cycle, hi/lo keep prior values.
- Drive reset=0 asynchronously mid-RUN after hi/lo hold nonzero values -> hi=lo=0, busy=0 immediately. Release reset and run MULTU 3*4 -> lo=12, hi=0.
